// File: rtl/decade_down_timer.sv
// rtl/decade_down_timer.sv - two-digit BCD down timer with parallel load, one-shot or periodic reload
module decade_down_timer #(
    parameter bit RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] din_tens,
    input  logic [3:0] din_ones,
    input  logic       start,
    input  logic       en,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       zero,
    output logic       done,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [7:0] rv_q, rv_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic cnt_zero, cnt_one, rv_zero, din_valid;

    assign cnt_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign cnt_one   = (tens_q == 4'd0) && (ones_q == 4'd1);
    assign rv_zero   = (rv_q == 8'h00);
    assign din_valid = (din_tens <= 4'd9) && (din_ones <= 4'd9);

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        rv_d    = rv_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (load) begin
            // A rejected load leaves everything but the error flag alone.
            if (din_valid) begin
                tens_d  = din_tens;
                ones_d  = din_ones;
                rv_d    = {din_tens, din_ones};
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !cnt_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    if (start && !rv_zero) begin
                        tens_d  = rv_q[7:4];
                        ones_d  = rv_q[3:0];
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        if (cnt_zero) begin
                            // Only reachable in periodic mode: reload, or give up on an empty reload value.
                            if (RELOAD && !rv_zero) begin
                                tens_d = rv_q[7:4];
                                ones_d = rv_q[3:0];
                            end else begin
                                state_d = ST_EXPIRED;
                            end
                        end else begin
                            if (ones_q != 4'd0) begin
                                ones_d = ones_q - 4'd1;
                            end else begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end
                            if (cnt_one) begin
                                done_d = 1'b1;
                                if (!RELOAD) begin
                                    state_d = ST_EXPIRED;
                                end
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            rv_q    <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;
    assign zero = cnt_zero;
    assign done = done_q;
    assign busy = (state_q == ST_RUN);
    assign err  = err_q;

endmodule

// File: tb/tb_decade_down_timer.sv
// tb/tb_decade_down_timer.sv - directed-vector bench for decade_down_timer, one-shot and periodic instances
module tb_decade_down_timer;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] din_tens;
    logic [3:0] din_ones;
    logic       start;
    logic       en;

    logic [3:0] os_tens, os_ones, pd_tens, pd_ones;
    logic       os_zero, os_done, os_busy, os_err;
    logic       pd_zero, pd_done, pd_busy, pd_err;

    int n_tests = 0;
    int n_fail  = 0;

    decade_down_timer #(.RELOAD(1'b0)) u_os (
        .clk(clk), .rst(rst), .load(load), .din_tens(din_tens), .din_ones(din_ones),
        .start(start), .en(en), .tens(os_tens), .ones(os_ones), .zero(os_zero),
        .done(os_done), .busy(os_busy), .err(os_err)
    );

    decade_down_timer #(.RELOAD(1'b1)) u_pd (
        .clk(clk), .rst(rst), .load(load), .din_tens(din_tens), .din_ones(din_ones),
        .start(start), .en(en), .tens(pd_tens), .ones(pd_ones), .zero(pd_zero),
        .done(pd_done), .busy(pd_busy), .err(pd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load     = 1'b1;
        din_tens = t;
        din_ones = o;
        tick();
        load     = 1'b0;
    endtask

    function automatic int bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    initial begin
        int rem;
        int prev;
        logic en_now;

        rst = 1'b0; load = 1'b0; start = 1'b0; en = 1'b0;
        din_tens = 4'd0; din_ones = 4'd0;
        #3;
        check("rst_cnt",  {os_tens, os_ones}, 'h00);
        check("rst_zero", os_zero, 1);
        check("rst_busy", os_busy, 0);
        check("rst_done", os_done, 0);
        check("rst_err",  os_err,  0);
        tick();
        rst = 1'b1;

        // one-shot run from 23, en held high
        do_load(4'd2, 4'd3);
        check("ld23_cnt",  {os_tens, os_ones}, 'h23);
        check("ld23_busy", os_busy, 0);
        check("ld23_zero", os_zero, 0);
        start = 1'b1; tick(); start = 1'b0;
        check("st23_busy", os_busy, 1);
        check("st23_cnt",  {os_tens, os_ones}, 'h23);
        check("st23_done", os_done, 0);
        en = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            tick();
            rem = 23 - k;
            check("run23_cnt",  {os_tens, os_ones}, bcd(rem));
            check("run23_done", os_done, (rem == 0) ? 1 : 0);
            check("run23_busy", os_busy, (rem != 0) ? 1 : 0);
        end
        check("exp_zero", os_zero, 1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("exp_hold_cnt",  {os_tens, os_ones}, 'h00);
            check("exp_hold_done", os_done, 0);
            check("exp_hold_busy", os_busy, 0);
        end
        start = 1'b1; tick(); start = 1'b0;
        check("exp_restart_busy", os_busy, 1);
        check("exp_restart_cnt",  {os_tens, os_ones}, 'h23);
        en = 1'b0;

        // load 05 while running, then en toggling
        do_load(4'd0, 4'd5);
        check("ld05_busy", os_busy, 0);
        check("ld05_cnt",  {os_tens, os_ones}, 'h05);
        start = 1'b1; tick(); start = 1'b0;
        rem = 5;
        for (int i = 0; i < 14; i++) begin
            en_now = (i % 2 == 0);
            en = en_now;
            tick();
            prev = rem;
            if (en_now && rem > 0) rem--;
            check("tog_cnt",  {os_tens, os_ones}, bcd(rem));
            check("tog_done", os_done, (en_now && prev == 1) ? 1 : 0);
        end
        en = 1'b0;

        // invalid loads and sticky error
        do_load(4'd4, 4'd2);
        check("ld42_cnt", {os_tens, os_ones}, 'h42);
        check("ld42_err", os_err, 0);
        do_load(4'hA, 4'd0);
        check("badA_cnt", {os_tens, os_ones}, 'h42);
        check("badA_err", os_err, 1);
        tick();
        check("err_sticky", os_err, 1);
        do_load(4'd0, 4'd7);
        check("ld07_cnt", {os_tens, os_ones}, 'h07);
        check("ld07_err", os_err, 0);
        do_load(4'd1, 4'hF);
        check("badF_cnt", {os_tens, os_ones}, 'h07);
        check("badF_err", os_err, 1);

        // load+start together in RUN at 15
        do_load(4'd2, 4'd0);
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        en = 1'b0;
        check("at15_cnt",  {os_tens, os_ones}, 'h15);
        check("at15_busy", os_busy, 1);
        load = 1'b1; start = 1'b1; din_tens = 4'd3; din_ones = 4'd1;
        tick();
        load = 1'b0; start = 1'b0;
        check("ldst_cnt",  {os_tens, os_ones}, 'h31);
        check("ldst_busy", os_busy, 0);
        check("ldst_done", os_done, 0);
        tick();
        check("ldst_idle", os_busy, 0);

        // async reset mid-RUN at 37
        do_load(4'd4, 4'd0);
        do_load(4'hF, 4'd0);
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        en = 1'b0;
        check("at37_cnt",  {os_tens, os_ones}, 'h37);
        check("at37_busy", os_busy, 1);
        check("at37_err",  os_err, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_cnt",  {os_tens, os_ones}, 'h00);
        check("arst_zero", os_zero, 1);
        check("arst_busy", os_busy, 0);
        check("arst_done", os_done, 0);
        check("arst_err",  os_err,  0);
        #1 rst = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("post_rst_busy", os_busy, 0);
        check("post_rst_cnt",  {os_tens, os_ones}, 'h00);
        check("post_rst_done", os_done, 0);

        // periodic instance: 03,02,01,00,03,...
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        do_load(4'd0, 4'd3);
        start = 1'b1; tick(); start = 1'b0;
        check("pd_st_busy", pd_busy, 1);
        check("pd_st_cnt",  {pd_tens, pd_ones}, 'h03);
        en = 1'b1;
        rem = 3;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (rem == 0) rem = 3; else rem--;
            check("pd_cnt",  {pd_tens, pd_ones}, bcd(rem));
            check("pd_done", pd_done, (rem == 0) ? 1 : 0);
            check("pd_busy", pd_busy, 1);
        end
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("pd_pause_cnt",  {pd_tens, pd_ones}, 'h00);
            check("pd_pause_done", pd_done, 0);
            check("pd_pause_busy", pd_busy, 1);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        check("pd_reload_cnt",  {pd_tens, pd_ones}, 'h03);
        check("pd_reload_done", pd_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
